// File: rtl/watch_btn_ctrl.sv
// Watch push-button front end: synchronises five raw buttons, qualifies presses by hold
// time, arbitrates by fixed priority and emits single-cycle command pulses and confirm LEDs.
module watch_btn_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 15_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_clear,
  input  logic btn_mode,
  input  logic btn_shift,
  input  logic btn_inc,
  input  logic btn_ss,
  output logic cmd_clear,
  output logic cmd_mode,
  output logic cmd_shift,
  output logic cmd_inc,
  output logic cmd_ss,
  output logic mode_conf,
  output logic shift_conf,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, QUAL, HELD, WAIT_REL} state_t;

  // Button index doubles as priority rank: lower index wins.
  localparam logic [2:0] IDX_MODE  = 3'd1;
  localparam logic [2:0] IDX_SHIFT = 3'd2;
  localparam logic [2:0] IDX_INC   = 3'd3;

  localparam logic [31:0] HOLD_LIM   = 32'(HOLD_CYCLES);
  localparam logic [31:0] REPEAT_LIM = 32'(REPEAT_CYCLES - 1);

  state_t      state;
  logic [4:0]  raw, s1, s2, cmd;
  logic [2:0]  owner, first_idx;
  logic [31:0] cnt;
  logic        own_high;

  assign raw      = {btn_ss, btn_inc, btn_shift, btn_mode, btn_clear};
  assign own_high = s2[owner];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // and a latch can never be inferred.
  always_comb begin
    first_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (s2[i]) first_idx = 3'(i);
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      cmd        <= '0;
      owner      <= '0;
      cnt        <= '0;
      state      <= IDLE;
      busy       <= 1'b0;
      mode_conf  <= 1'b0;
      shift_conf <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cmd <= '0;
      case (state)
        IDLE: begin
          if (|s2) begin
            owner <= first_idx;
            cnt   <= 32'd1;
            state <= QUAL;
            busy  <= 1'b1;
          end
        end
        QUAL: begin
          if (!own_high) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == HOLD_LIM) begin
            cmd   <= 5'b00001 << owner;
            cnt   <= '0;
            state <= HELD;
            if (owner == IDX_MODE)  mode_conf  <= 1'b1;
            if (owner == IDX_SHIFT) shift_conf <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HELD: begin
          if (!own_high) begin
            state <= WAIT_REL;
          end else if (REPEAT_EN && owner == IDX_INC) begin
            // Pulse on the edge the count would reach the period, keeping exact spacing.
            if (cnt == REPEAT_LIM) begin
              cmd <= 5'b01000;
              cnt <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        WAIT_REL: begin
          if (s2 == 5'b0) begin
            cnt        <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            mode_conf  <= 1'b0;
            shift_conf <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_clear = cmd[0];
  assign cmd_mode  = cmd[1];
  assign cmd_shift = cmd[2];
  assign cmd_inc   = cmd[3];
  assign cmd_ss    = cmd[4];

endmodule
